// File: rtl/btn_led_ctrl.sv
// Multi-channel key-to-LED controller: per-channel sync + debounce + press detect,
// LED driven in follow / toggle / blink / off mode from a shared blink prescaler.

module btn_led_chan #(
    parameter int DEB_CYCLES  = 10000,
    parameter int KEY_ACT_LOW = 1,
    parameter int LED_ACT_LOW = 0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key,
    input  logic [1:0] mode,
    input  logic       phase,
    output logic       led,
    output logic       key_state,
    output logic       key_press
);
    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);
    localparam logic KEY_IDLE = 1'(KEY_ACT_LOW);
    localparam logic LED_INV  = 1'(LED_ACT_LOW);

    logic [1:0]    sync;
    logic          pressed;
    logic [CW-1:0] cnt;
    logic          tgl;
    logic          led_on;

    // sync flops idle at the released pin level so reset never looks like a press
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= {2{KEY_IDLE}};
        else        sync <= {sync[0], key};
    end

    assign pressed = sync[1] ^ KEY_IDLE;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            key_state <= 1'b0;
            key_press <= 1'b0;
            tgl       <= 1'b0;
        end else begin
            key_press <= 1'b0;
            if (pressed == key_state) begin
                cnt <= '0;
            end else if (cnt == CNT_MAX) begin
                cnt       <= '0;
                key_state <= pressed;
                // tgl flips on the same edge as the press pulse, so the LED follows one clock later
                if (pressed) begin
                    key_press <= 1'b1;
                    if (mode == 2'b01 || mode == 2'b10) tgl <= ~tgl;
                end
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

    always_comb begin
        led_on = 1'b0;
        case (mode)
            2'b00:   led_on = key_state;
            2'b01:   led_on = tgl;
            2'b10:   led_on = tgl & phase;
            default: led_on = 1'b0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) led <= LED_INV;
        else        led <= led_on ^ LED_INV;
    end
endmodule

module btn_led_ctrl #(
    parameter int N_CH        = 2,
    parameter int DEB_CYCLES  = 10000,
    parameter int BLINK_HALF  = 25000,
    parameter int KEY_ACT_LOW = 1,
    parameter int LED_ACT_LOW = 0
) (
    input  logic            F_CLK,
    input  logic            F_RST_N,
    input  logic [N_CH:1]   F_KEY,
    input  logic [2*N_CH:1] MODE,
    output logic [N_CH:1]   F_LED,
    output logic [N_CH:1]   KEY_STATE,
    output logic [N_CH:1]   KEY_PRESS
);
    localparam int PW = (BLINK_HALF > 1) ? $clog2(BLINK_HALF) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(BLINK_HALF - 1);

    logic [PW-1:0] pre;
    logic          phase;

    // shared free-running blink timebase; phase inverts on every prescaler wrap
    always_ff @(posedge F_CLK or negedge F_RST_N) begin
        if (!F_RST_N) begin
            pre   <= '0;
            phase <= 1'b0;
        end else if (pre == PRE_MAX) begin
            pre   <= '0;
            phase <= ~phase;
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar g = 1; g <= N_CH; g++) begin : g_ch
        btn_led_chan #(
            .DEB_CYCLES (DEB_CYCLES),
            .KEY_ACT_LOW(KEY_ACT_LOW),
            .LED_ACT_LOW(LED_ACT_LOW)
        ) u_ch (
            .clk      (F_CLK),
            .rst_n    (F_RST_N),
            .key      (F_KEY[g]),
            .mode     (MODE[2*g -: 2]),
            .phase    (phase),
            .led      (F_LED[g]),
            .key_state(KEY_STATE[g]),
            .key_press(KEY_PRESS[g])
        );
    end
endmodule

// File: tb/tb_btn_led_ctrl.sv
// Directed bench for btn_led_ctrl: expected outputs are queued with their due cycle
// when stimulus is applied and compared by a monitor when that cycle arrives.

module tb_btn_led_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:1] key;
    logic [4:1] mode;
    logic [2:1] led, st, pr;
    logic [2:1] led_al, st_al, pr_al;

    typedef struct {
        int         cyc;
        logic [1:0] led;
        logic [1:0] st;
        logic [1:0] pr;
        string      tag;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   cyc = 0;
    int   rel = 0;
    int   errors = 0;
    int   checks = 0;
    int   pcnt2 = 0;
    int   p0;

    btn_led_ctrl #(.N_CH(2), .DEB_CYCLES(4), .BLINK_HALF(3), .KEY_ACT_LOW(1), .LED_ACT_LOW(0)) dut (
        .F_CLK(clk), .F_RST_N(rst_n), .F_KEY(key), .MODE(mode),
        .F_LED(led), .KEY_STATE(st), .KEY_PRESS(pr)
    );

    btn_led_ctrl #(.N_CH(2), .DEB_CYCLES(4), .BLINK_HALF(3), .KEY_ACT_LOW(1), .LED_ACT_LOW(1)) dut_al (
        .F_CLK(clk), .F_RST_N(rst_n), .F_KEY(key), .MODE(mode),
        .F_LED(led_al), .KEY_STATE(st_al), .KEY_PRESS(pr_al)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(negedge clk) if (pr[2]) pcnt2++;

    task automatic check(input exp_t e);
        checks++;
        assert (led === e.led) else begin errors++; $error("FAIL %s led: got %b want %b", e.tag, led, e.led); end
        checks++;
        assert (led_al === ~e.led) else begin errors++; $error("FAIL %s led_al: got %b want %b", e.tag, led_al, ~e.led); end
        checks++;
        assert (st === e.st) else begin errors++; $error("FAIL %s state: got %b want %b", e.tag, st, e.st); end
        checks++;
        assert (st_al === e.st) else begin errors++; $error("FAIL %s state_al: got %b want %b", e.tag, st_al, e.st); end
        checks++;
        assert (pr === e.pr) else begin errors++; $error("FAIL %s press: got %b want %b", e.tag, pr, e.pr); end
        checks++;
        assert (pr_al === e.pr) else begin errors++; $error("FAIL %s press_al: got %b want %b", e.tag, pr_al, e.pr); end
    endtask

    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc == cyc) begin
                cur = sb[i];
                sb.delete(i);
                check(cur);
            end
        end
    end

    task automatic push(input int dt, input logic [1:0] l, input logic [1:0] s,
                        input logic [1:0] p, input string tag);
        exp_t e;
        e.cyc = cyc + dt; e.led = l; e.st = s; e.pr = p; e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // blink phase after a given posedge, counted from the first edge after reset release
    function automatic logic ph(input int c);
        return (((c - rel) / 3) % 2) == 1;
    endfunction

    initial begin
        rst_n = 1'b0; key = 2'b11; mode = 4'b0000;
        for (int d = 1; d <= 3; d++) push(d, 2'b00, 2'b00, 2'b00, "rst");
        step(3);
        rst_n = 1'b1; rel = cyc;
        for (int d = 1; d <= 3; d++) push(d, 2'b00, 2'b00, 2'b00, "idle");
        step(3);

        // glitch shorter than the debounce window
        key = 2'b10;
        for (int d = 1; d <= 10; d++) push(d, 2'b00, 2'b00, 2'b00, "glitch");
        step(3);
        key = 2'b11;
        step(8);

        // follow mode, press and release key 1
        key = 2'b10;
        push(5, 2'b00, 2'b00, 2'b00, "fol_pre");
        push(6, 2'b00, 2'b01, 2'b01, "fol_press");
        push(7, 2'b01, 2'b01, 2'b00, "fol_led");
        push(8, 2'b01, 2'b01, 2'b00, "fol_hold");
        step(10);
        key = 2'b11;
        push(5, 2'b01, 2'b01, 2'b00, "rel_pre");
        push(6, 2'b01, 2'b00, 2'b00, "rel_state");
        push(7, 2'b00, 2'b00, 2'b00, "rel_led");
        step(10);

        // toggle mode, two presses on key 2
        p0 = pcnt2;
        mode = 4'b0101; key = 2'b01;
        push(6, 2'b00, 2'b10, 2'b10, "tg1_press");
        push(7, 2'b10, 2'b10, 2'b00, "tg1_led");
        step(8);
        key = 2'b11;
        push(6, 2'b10, 2'b00, 2'b00, "tg1_rel");
        push(7, 2'b10, 2'b00, 2'b00, "tg1_hold");
        step(8);
        key = 2'b01;
        push(6, 2'b10, 2'b10, 2'b10, "tg2_press");
        push(7, 2'b00, 2'b10, 2'b00, "tg2_led");
        step(8);
        key = 2'b11;
        push(7, 2'b00, 2'b00, 2'b00, "tg2_rel");
        step(8);
        checks++;
        assert (pcnt2 - p0 == 2) else begin errors++; $error("FAIL press_count: got %0d want 2", pcnt2 - p0); end

        // blink mode on key 1
        mode = 4'b0010; key = 2'b10;
        push(6, 2'b00, 2'b01, 2'b01, "bl_press");
        for (int d = 7; d <= 18; d++) push(d, {1'b0, ph(cyc + d - 1)}, 2'b01, 2'b00, "blink");
        step(18);
        key = 2'b11;
        step(10);
        mode = 4'b0011;
        push(1, 2'b00, 2'b00, 2'b00, "off");
        push(2, 2'b00, 2'b00, 2'b00, "off2");
        step(2);
        mode = 4'b0001;
        push(1, 2'b01, 2'b00, 2'b00, "tgl_kept");
        push(2, 2'b01, 2'b00, 2'b00, "tgl_kept2");
        step(2);

        // reset two clocks into a debounce, key held through release
        mode = 4'b0000; key = 2'b10;
        push(1, 2'b00, 2'b00, 2'b00, "mid_pre");
        step(2);
        rst_n = 1'b0;
        push(1, 2'b00, 2'b00, 2'b00, "mid_rst");
        step(1);
        rst_n = 1'b1;
        for (int d = 1; d <= 5; d++) push(d, 2'b00, 2'b00, 2'b00, "mid_nopress");
        push(6, 2'b00, 2'b01, 2'b01, "mid_redeb");
        push(7, 2'b01, 2'b01, 2'b00, "mid_led");
        step(8);
        key = 2'b11;
        push(7, 2'b00, 2'b00, 2'b00, "end_rel");
        step(9);

        checks++;
        assert (sb.size() == 0) else begin errors++; $error("FAIL sb_drain: got %0d want 0", sb.size()); end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
